// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between the IF and MEM pipeline
// stages. Requests are serialised through a three-state FSM with round-robin
// tie-breaking, bus waits are bounded by a timeout, and per-stage stall
// signals are produced for the hazard unit.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction-fetch port
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ready,
  output logic                  if_stall,
  // data-access port
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [DATA_W/8-1:0]   mem_be,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_stall,
  // memory bus
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_W/8-1:0]   bus_be,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_W-1:0]     bus_rdata,
  // status
  output logic [1:0]            grant,
  output logic                  bus_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    MEM_BUSY
  } state_t;

  state_t             state;
  logic               last_mem;   // 1 when the last completed grant was MEM
  logic [CNT_W-1:0]   wait_cnt;
  logic               if_elig;
  logic               mem_elig;
  logic               pick_mem;
  logic               timed_out;
  logic [DATA_W-1:0]  done_data;

  // A port is not eligible in its own completion cycle, so a request held
  // through ready is not re-issued.
  assign if_elig   = if_req & ~if_ready;
  assign mem_elig  = mem_req & ~mem_ready;
  assign pick_mem  = mem_elig & (~if_elig | ~last_mem);
  assign timed_out = TO_EN && (wait_cnt == TO_LIMIT);
  assign done_data = bus_ack ? bus_rdata : '0;

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_req & ~mem_ready;

  // Arbitration FSM with registered bus fields, ready pulses and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_mem  <= 1'b0;
      wait_cnt  <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      grant     <= 2'b00;
      bus_err   <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (if_elig || mem_elig) begin
            bus_req  <= 1'b1;
            wait_cnt <= '0;
            if (pick_mem) begin
              state     <= MEM_BUSY;
              grant     <= 2'b10;
              bus_we    <= mem_we;
              bus_be    <= mem_be;
              bus_addr  <= mem_addr;
              bus_wdata <= mem_wdata;
            end else begin
              state     <= IF_BUSY;
              grant     <= 2'b01;
              bus_we    <= 1'b0;
              bus_be    <= '1;
              bus_addr  <= if_addr;
              bus_wdata <= '0;
            end
          end
        end
        IF_BUSY, MEM_BUSY: begin
          if (bus_ack || timed_out) begin
            if (state == IF_BUSY) begin
              if_rdata <= done_data;
              if_ready <= 1'b1;
              last_mem <= 1'b0;
            end else begin
              mem_rdata <= done_data;
              mem_ready <= 1'b1;
              last_mem  <= 1'b1;
            end
            if (!bus_ack) bus_err <= 1'b1;
            bus_req <= 1'b0;
            grant   <= 2'b00;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized phase, all checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_ready, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          mem_req, mem_we, mem_ready, mem_stall;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          bus_req, bus_we, bus_ack, bus_err;
  logic [BW-1:0] bus_be;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [1:0]    grant;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .grant(grant), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: one outstanding transaction described by its grant
  // cycle, completion cycle and ack cycle
  int            cyc;
  bit            have_txn;
  int            g_cyc, done_cyc, ack_cyc;
  logic [1:0]    owner;
  bit            m_last_mem, m_err, m_to;
  logic [DW-1:0] m_if_rdata, m_mem_rdata, m_rnext;
  logic          l_we;
  logic [BW-1:0] l_be;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  bit            exp_if_rdy, exp_mem_rdy;
  int            fixed_dly;
  logic [DW-1:0] fixed_data;

  // observations of the DUT for directed checks
  int            n_breq, n_ifstall, n_memrdy, last_memrdy_cyc;
  logic          prev_breq;
  logic [1:0]    grant_log[$];
  logic [AW-1:0] addr_log[$];
  int            rise_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit busy_at(input int c);
    return have_txn && (c > g_cyc) && (c < done_cyc);
  endfunction

  task automatic model_reset();
    have_txn = 0; g_cyc = -10; done_cyc = -10; ack_cyc = -10; owner = 2'b00;
    m_last_mem = 0; m_err = 0; m_to = 0;
    m_if_rdata = '0; m_mem_rdata = '0; m_rnext = '0;
    exp_if_rdy = 0; exp_mem_rdy = 0; prev_breq = 1'b0;
  endtask

  task automatic check_outputs();
    bit b;
    b = busy_at(cyc);
    chk("bus_req", bus_req, b);
    chk("grant", grant, b ? owner : 2'b00);
    chk("if_ready", if_ready, exp_if_rdy);
    chk("mem_ready", mem_ready, exp_mem_rdy);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("mem_rdata", mem_rdata, m_mem_rdata);
    chk("bus_err", bus_err, m_err);
    if (b) begin
      chk("bus_we", bus_we, l_we);
      chk("bus_be", bus_be, l_be);
      chk("bus_addr", bus_addr, l_addr);
      chk("bus_wdata", bus_wdata, l_wdata);
    end
    if (bus_req && !prev_breq) begin
      grant_log.push_back(grant);
      addr_log.push_back(bus_addr);
      rise_log.push_back(cyc);
    end
    prev_breq = bus_req;
    if (bus_req) n_breq++;
    if (mem_ready) begin n_memrdy++; last_memrdy_cyc = cyc; end
  endtask

  // Apply the slave and arbitration model for the current cycle, then
  // advance one clock and check the registered outputs.
  task automatic tick();
    bit idle_now, ife, mme, pm;
    int d, eff;
    idle_now = !busy_at(cyc);
    ife = if_req && !exp_if_rdy;
    mme = mem_req && !exp_mem_rdy;
    if (idle_now) begin
      bus_ack   = ($urandom_range(0, 3) == 0);
      bus_rdata = $urandom;
    end else begin
      bus_ack   = (cyc == ack_cyc);
      bus_rdata = bus_ack ? m_rnext : $urandom;
    end
    if (idle_now && (ife || mme)) begin
      pm = mme && (!ife || !m_last_mem);
      if (fixed_dly >= 0) d = fixed_dly;
      else d = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(4, 6);
      eff      = (d <= T) ? d : T;
      have_txn = 1;
      g_cyc    = cyc;
      done_cyc = cyc + eff + 2;
      ack_cyc  = (d <= T) ? cyc + 1 + d : -10;
      m_to     = (d > T);
      m_rnext  = (d > T) ? '0 : ((fixed_dly >= 0) ? fixed_data : DW'($urandom));
      owner    = pm ? 2'b10 : 2'b01;
      l_we     = pm ? mem_we : 1'b0;
      l_be     = pm ? mem_be : '1;
      l_addr   = pm ? mem_addr : if_addr;
      l_wdata  = pm ? mem_wdata : '0;
    end
    #1;
    chk("if_stall", if_stall, if_req & ~exp_if_rdy);
    chk("mem_stall", mem_stall, mem_req & ~exp_mem_rdy);
    if (if_stall) n_ifstall++;
    @(posedge clk);
    #1;
    cyc++;
    exp_if_rdy  = have_txn && (cyc == done_cyc) && (owner == 2'b01);
    exp_mem_rdy = have_txn && (cyc == done_cyc) && (owner == 2'b10);
    if (exp_if_rdy)  m_if_rdata  = m_rnext;
    if (exp_mem_rdy) m_mem_rdata = m_rnext;
    if (exp_if_rdy || exp_mem_rdy) begin
      m_last_mem = (owner == 2'b10);
      if (m_to) m_err = 1;
    end
    check_outputs();
  endtask

  // Tick until the chosen port's ready cycle; returns inside that cycle.
  task automatic run_until(input bit want_mem, input int max);
    int k;
    for (k = 0; k < max; k++) begin
      tick();
      if (want_mem ? exp_mem_rdy : exp_if_rdy) break;
    end
    chk("wait_bound", (k < max), 1'b1);
  endtask

  // Stage-like masters: hold a request until ready, scramble a granted
  // port's inputs while busy (the arbiter must use its latched copy).
  task automatic rand_stim();
    if (!if_req || exp_if_rdy) begin
      if_req  = (if_req && exp_if_rdy) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
      if_addr = $urandom;
    end else if (busy_at(cyc) && owner == 2'b01) begin
      if_addr = $urandom;
    end
    if (!mem_req || exp_mem_rdy) begin
      mem_req   = (mem_req && exp_mem_rdy) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
      mem_we    = 1'($urandom_range(0, 1));
      mem_be    = BW'($urandom);
      mem_addr  = $urandom;
      mem_wdata = $urandom;
    end else if (busy_at(cyc) && owner == 2'b10) begin
      mem_we    = 1'($urandom_range(0, 1));
      mem_be    = BW'($urandom);
      mem_addr  = $urandom;
      mem_wdata = $urandom;
    end
  endtask

  initial begin
    int n0;
    rst = 1'b0;
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_be = '0;
    mem_addr = '0; mem_wdata = '0; bus_ack = 0; bus_rdata = '0;
    n_breq = 0; n_ifstall = 0; n_memrdy = 0; last_memrdy_cyc = -1;
    fixed_dly = 0; fixed_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_bus_be", bus_be, '0);
    rst = 1'b1;
    cyc = 0;
    check_outputs();

    // single fetch, ack on the third bus_req cycle
    fixed_dly = 2; fixed_data = 32'h2400_0001;
    n_breq = 0; n_ifstall = 0;
    if_req = 1; if_addr = 32'h100;
    run_until(0, 20);
    chk("fetch_breq_cycles", n_breq, 3);
    chk("fetch_stall_cycles", n_ifstall, 4);
    chk("fetch_rdata", if_rdata, 32'h2400_0001);
    chk("fetch_grant", grant_log[grant_log.size()-1], 2'b01);
    if_req = 0;
    tick();

    // simultaneous requests: MEM first, then IF; later tie after MEM goes to IF
    n0 = grant_log.size();
    fixed_dly = 1; fixed_data = 32'h1111_2222;
    if_req = 1; if_addr = 32'h104;
    mem_req = 1; mem_we = 0; mem_be = '1; mem_addr = 32'h200; mem_wdata = '0;
    run_until(1, 20);
    mem_req = 0;
    run_until(0, 20);
    if_req = 0;
    tick();
    mem_req = 1; mem_addr = 32'h204;
    run_until(1, 20);
    mem_req = 0;
    tick();
    if_req = 1; if_addr = 32'h108; mem_req = 1; mem_addr = 32'h208;
    run_until(0, 20);
    if_req = 0;
    run_until(1, 20);
    mem_req = 0;
    tick();
    chk("tie1_mem_first", grant_log[n0], 2'b10);
    chk("tie1_if_second", grant_log[n0+1], 2'b01);
    chk("tie2_if_wins", grant_log[n0+3], 2'b01);
    chk("tie2_mem_after", grant_log[n0+4], 2'b10);

    // store with fields checked while busy and inputs scrambled
    fixed_dly = 3; fixed_data = 32'h5555_AAAA;
    n_breq = 0; n_memrdy = 0;
    mem_req = 1; mem_we = 1; mem_be = 4'b0011; mem_addr = 32'h3C; mem_wdata = 32'hCAFE_BABE;
    tick();
    chk("st_we", bus_we, 1'b1);
    chk("st_be", bus_be, 4'b0011);
    chk("st_addr", bus_addr, 32'h3C);
    chk("st_wdata", bus_wdata, 32'hCAFE_BABE);
    mem_we = 0; mem_be = 4'hF; mem_addr = 32'h0; mem_wdata = 32'h0;
    tick(); tick();
    chk("st_addr_held", bus_addr, 32'h3C);
    chk("st_wdata_held", bus_wdata, 32'hCAFE_BABE);
    run_until(1, 20);
    tick();
    mem_req = 0;
    repeat (3) tick();
    chk("st_breq_cycles", n_breq, 4);
    chk("st_ready_pulses", n_memrdy, 1);

    // back-to-back fetches with zero-wait slave
    n0 = rise_log.size();
    fixed_dly = 0; fixed_data = 32'h0BAD_F00D;
    n_breq = 0;
    if_req = 1; if_addr = 32'h400;
    run_until(0, 20);
    if_addr = 32'h404;
    run_until(0, 20);
    if_req = 0;
    tick();
    chk("b2b_breq_cycles", n_breq, 2);
    chk("b2b_rise_gap", rise_log[n0+1] - rise_log[n0], 3);
    chk("b2b_addr0", addr_log[n0], 32'h400);
    chk("b2b_addr1", addr_log[n0+1], 32'h404);

    // timeout: slave never acks
    n0 = rise_log.size();
    fixed_dly = T + 2;
    mem_req = 1; mem_we = 0; mem_be = '1; mem_addr = 32'h500;
    run_until(1, 30);
    mem_req = 0;
    chk("to_latency", last_memrdy_cyc - rise_log[n0], T + 1);
    chk("to_rdata", mem_rdata, 32'h0);
    chk("to_err", bus_err, 1'b1);
    tick();
    fixed_dly = 1; fixed_data = 32'h7777_0000;
    if_req = 1; if_addr = 32'h510;
    run_until(0, 20);
    if_req = 0;
    tick();
    chk("err_sticky", bus_err, 1'b1);

    // reset in the middle of a MEM transaction
    fixed_dly = T + 2;
    mem_req = 1; mem_addr = 32'h600; mem_wdata = 32'h1234_5678; mem_we = 1;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_bus_req", bus_req, 1'b0);
    chk("arst_grant", grant, 2'b00);
    chk("arst_bus_err", bus_err, 1'b0);
    chk("arst_bus_addr", bus_addr, '0);
    chk("arst_bus_wdata", bus_wdata, '0);
    chk("arst_bus_we", bus_we, 1'b0);
    chk("arst_if_rdata", if_rdata, '0);
    chk("arst_mem_ready", mem_ready, 1'b0);
    mem_req = 0; mem_we = 0;
    if_req = 1; if_addr = 32'h700;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
    model_reset();
    check_outputs();
    fixed_dly = 1; fixed_data = 32'h0000_0700;
    run_until(0, 20);
    if_req = 0;
    chk("post_rst_grant", grant_log[grant_log.size()-1], 2'b01);
    chk("post_rst_addr", addr_log[addr_log.size()-1], 32'h700);
    tick();

    // randomized traffic
    fixed_dly = -1;
    for (int i = 0; i < 1500; i++) begin
      rand_stim();
      tick();
    end
    if_req = 0; mem_req = 0;
    repeat (T + 4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
